// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types, constants and helpers for the serial stages
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } serial_state_e;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // Bits needed to hold values 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_bit_feeder_bit_down_counter.sv
// rtl/serial_bit_feeder_bit_down_counter.sv - loadable down-counter with zero flag
module bit_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - MSB-first word serializer with valid/ready input
// Optional trailing even-parity bit enabled by SERIAL_FEEDER_PARITY_EN.
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             X,
  output logic             X_VALID,
  output logic             LAST,
  output logic             BUSY
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  serial_state_e    state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CW-1:0]    cnt_val;
  logic             cnt_zero;
  logic             accept;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  bit_down_counter #(.W(CW)) u_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  assign accept = DIN_VALID && DIN_READY;
  assign BUSY   = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    DIN_READY = 1'b0;
    X         = IDLE_BIT;
    X_VALID   = 1'b0;
    LAST      = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        DIN_READY = RST_N;
      end
      SHIFT: begin
        X       = shreg_q[WIDTH-1];
        X_VALID = 1'b1;
        if (cnt_zero) begin
`ifdef SERIAL_FEEDER_PARITY_EN
          state_d = PARITY;
`else
          LAST      = 1'b1;
          DIN_READY = RST_N;
          if (!accept) begin
            state_d = IDLE;
          end
`endif
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_dec = 1'b1;
        end
      end
`ifdef SERIAL_FEEDER_PARITY_EN
      PARITY: begin
        X         = parity_q;
        X_VALID   = 1'b1;
        LAST      = 1'b1;
        DIN_READY = RST_N;
        if (!accept) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any accept, whichever state granted it, starts a fresh frame next cycle.
    if (accept) begin
      state_d  = SHIFT;
      shreg_d  = DIN;
      cnt_load = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_d = ^DIN;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
